// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: word offsets inside
// the 32-byte window and TCON bit positions.
package periph_pkg;

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LEDS    = 3'd3;
  localparam logic [2:0] OFF_DIGITS  = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN    = 0;
  localparam int TCON_IRQEN = 1;
  localparam int TCON_STAT  = 2;

endpackage

// File: rtl/periph_timer_core.sv
// Reload timer: TH/TL/TCON registers, overflow/reload logic and the merge of
// CPU writes with same-cycle timer updates.
module periph_timer_core
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;
    if (ovf && tcon_q[TCON_IRQEN]) tcon_d[TCON_STAT] = 1'b1;
    if (wr_en_i) begin
      case (wr_sel_i)
        OFF_TH: th_d = wr_data_i;
        OFF_TL: tl_d = wr_data_i;
        OFF_TCON: begin
          // A software write must not swallow an overflow landing in the same cycle.
          tcon_d = wr_data_i[2:0];
          if (ovf && wr_data_i[TCON_IRQEN]) tcon_d[TCON_STAT] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_STAT] & tcon_q[TCON_IRQEN];

endmodule

// File: rtl/periph_mmio_responder.sv
// MMIO responder for a 32-byte window: decode, read mux, LEDS, DIGITS and an
// optional SYSTICK counter (present when PERIPH_SYSTICK_EN is defined).
module periph_mmio_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          LED_WIDTH   = 8,
  parameter int          DIGIT_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            i_address,
  input  logic [31:0]            i_mem_write_data,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  output logic [31:0]            o_mem_read_data,
  output logic                   o_hit,
  output logic                   o_irq,
  output logic [LED_WIDTH-1:0]   o_leds,
  output logic [DIGIT_WIDTH-1:0] o_digits
);

  logic [2:0]             sel;
  logic                   wr_en;
  logic [31:0]            th, tl;
  logic [2:0]             tcon;
  logic [LED_WIDTH-1:0]   leds_q;
  logic [DIGIT_WIDTH-1:0] digits_q;
  logic                   unused_byte_lanes;

  assign o_hit             = (i_address[31:5] == BASE_ADDR[31:5]);
  assign sel               = i_address[4:2];
  assign wr_en             = i_mem_write && o_hit;
  assign unused_byte_lanes = ^i_address[1:0];

  periph_timer_core u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_sel_i  (sel),
    .wr_data_i (i_mem_write_data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (o_irq)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      leds_q   <= '0;
      digits_q <= '0;
    end else if (wr_en) begin
      if (sel == OFF_LEDS)   leds_q   <= i_mem_write_data[LED_WIDTH-1:0];
      if (sel == OFF_DIGITS) digits_q <= i_mem_write_data[DIGIT_WIDTH-1:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q;

  always_ff @(posedge clk) begin
    if (!reset) systick_q <= '0;
    else        systick_q <= systick_q + 32'd1;
  end
`endif

  always_comb begin
    o_mem_read_data = '0;
    if (i_mem_read && o_hit) begin
      case (sel)
        OFF_TH:     o_mem_read_data = th;
        OFF_TL:     o_mem_read_data = tl;
        OFF_TCON:   o_mem_read_data = {29'd0, tcon};
        OFF_LEDS:   o_mem_read_data = 32'(leds_q);
        OFF_DIGITS: o_mem_read_data = 32'(digits_q);
`ifdef PERIPH_SYSTICK_EN
        OFF_SYSTICK: o_mem_read_data = systick_q;
`endif
        default:    o_mem_read_data = '0;
      endcase
    end
  end

  assign o_leds   = leds_q;
  assign o_digits = digits_q;

endmodule

// File: tb/tb_periph_mmio_responder.sv
// Self-checking bench for periph_mmio_responder: directed table, hand-written
// timer/collision sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_periph_mmio_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] i_address;
  logic [31:0] i_mem_write_data;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [31:0] o_mem_read_data;
  logic        o_hit;
  logic        o_irq;
  logic [7:0]  o_leds;
  logic [11:0] o_digits;

  periph_mmio_responder dut (
    .clk              (clk),
    .reset            (reset),
    .i_address        (i_address),
    .i_mem_write_data (i_mem_write_data),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .o_mem_read_data  (o_mem_read_data),
    .o_hit            (o_hit),
    .o_irq            (o_irq),
    .o_leds           (o_leds),
    .o_digits         (o_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks are entered just after a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_address        = a;
    i_mem_write_data = d;
    i_mem_read       = 1'b0;
    i_mem_write      = 1'b1;
    @(negedge clk);
    i_mem_write      = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    i_address  = a;
    i_mem_read = 1'b1;
    #1;
    d = o_mem_read_data;
    h = o_hit;
    i_mem_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: register file indexed by word offset plus timer flags.
  logic [31:0] m_th, m_tl, m_tick;
  logic        m_en, m_ie, m_st;
  logic [7:0]  m_leds;
  logic [11:0] m_digits;

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_tick = 0;
    m_en = 0; m_ie = 0; m_st = 0;
    m_leds = 0; m_digits = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] s);
    case (s)
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_st, m_ie, m_en};
      3'd3: return {24'd0, m_leds};
      3'd4: return {20'd0, m_digits};
      3'd5: begin
`ifdef PERIPH_SYSTICK_EN
        return m_tick;
`else
        return 32'h0;
`endif
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(input logic we, input logic [2:0] s, input logic [31:0] d);
    logic        wrap;
    logic [31:0] next_tl;
    logic        next_st;
    wrap    = m_en && (m_tl == 32'hFFFF_FFFF);
    next_tl = m_tl;
    if (m_en) next_tl = wrap ? m_th : m_tl + 1;
    next_st = m_st || (wrap && m_ie);
    if (we) begin
      if (s == 3'd0) m_th = d;
      if (s == 3'd1) next_tl = d;
      if (s == 3'd2) begin
        m_en    = d[0];
        m_ie    = d[1];
        next_st = d[2] || (wrap && d[1]);
      end
      if (s == 3'd3) m_leds = d[7:0];
      if (s == 3'd4) m_digits = d[11:0];
    end
    m_tl   = next_tl;
    m_st   = next_st;
    m_tick = m_tick + 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rv, ra, rb;
    logic        hv;

    vecs[0]  = '{32'h4000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[1]  = '{32'h4000_0008, 32'hFFFF_FFF8, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'h4000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{32'h4000_000C, 32'h0000_01A5, 32'h0000_00A5, 1'b1};
    vecs[4]  = '{32'h4000_0010, 32'h0000_ABCD, 32'h0000_0BCD, 1'b1};
    vecs[5]  = '{32'h4000_0018, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h4000_001C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h4000_0020, 32'h0000_0055, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h3FFF_FFFC, 32'h0000_0055, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'h4000_0008, 32'h0000_0006, 32'h0000_0006, 1'b1};
    vecs[10] = '{32'h4000_0008, 32'h0000_0000, 32'h0000_0000, 1'b1};

    reset = 1'b0; i_address = 0; i_mem_write_data = 0; i_mem_read = 0; i_mem_write = 0;

    // Reset held low: every register reads zero.
    idle(2);
    for (int i = 0; i < 6; i++) begin
      rd(BASE + 32'(i * 4), rv, hv);
      check($sformatf("reset_rd_%0d", i), rv, 32'h0);
      @(negedge clk);
    end
    check("reset_irq", {31'd0, o_irq}, 32'h0);
    check("reset_leds", {24'd0, o_leds}, 32'h0);
    check("reset_digits", {20'd0, o_digits}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rv, hv);
      check($sformatf("vec%0d_data", i), rv, vecs[i].exp_rd);
      check($sformatf("vec%0d_hit", i), {31'd0, hv}, {31'd0, vecs[i].exp_hit});
    end
    check("vec_leds_kept", {24'd0, o_leds}, 32'h0000_00A5);

    // LED store, byte-lane bits ignored, out-of-window load.
    wr(32'h4000_000C, 32'h0000_01A5);
    check("led_out", {24'd0, o_leds}, 32'h0000_00A5);
    rd(32'h4000_000F, rv, hv);
    check("led_rd_lanes", rv, 32'h0000_00A5);
    rd(32'h3FFF_FFFC, rv, hv);
    check("miss_hit", {31'd0, hv}, 32'h0);
    check("miss_data", rv, 32'h0);
    wr(32'h4000_0010, 32'hFFFF_FFFF);
    check("digits_out", {20'd0, o_digits}, 32'h0000_0FFF);

    // Read and write of the same register in one cycle: read sees old value.
    i_address = 32'h4000_000C; i_mem_write_data = 32'h3C;
    i_mem_read = 1'b1; i_mem_write = 1'b1;
    #1;
    check("rw_same_old", o_mem_read_data, 32'h0000_00A5);
    @(negedge clk);
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    check("rw_same_new", {24'd0, o_leds}, 32'h0000_003C);

    // Timer reload and irq.
    wr(32'h4000_0000, 32'hFFFF_FFF0);
    wr(32'h4000_0004, 32'hFFFF_FFFD);
    wr(32'h4000_0008, 32'h3);
    idle(2);
    check("reload_pre_irq", {31'd0, o_irq}, 32'h0);
    idle(1);
    rd(32'h4000_0004, rv, hv);
    check("reload_tl", rv, 32'hFFFF_FFF0);
    check("reload_irq", {31'd0, o_irq}, 32'h1);
    wr(32'h4000_0008, 32'h1);
    check("irq_clear", {31'd0, o_irq}, 32'h0);

    // TL write wins over an overflow.
    wr(32'h4000_0008, 32'h0);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'h3);
    idle(1);
    rd(32'h4000_0004, rv, hv);
    check("coll_tl_pre", rv, 32'hFFFF_FFFF);
    wr(32'h4000_0004, 32'h5);
    rd(32'h4000_0004, rv, hv);
    check("coll_tl_wins", rv, 32'h5);

    // TCON write in an overflow cycle keeps the status.
    wr(32'h4000_0008, 32'h0);
    check("coll_clr_irq", {31'd0, o_irq}, 32'h0);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'h3);
    idle(1);
    wr(32'h4000_0008, 32'h3);
    rd(32'h4000_0008, rv, hv);
    check("coll_tcon", rv, 32'h7);
    check("coll_irq", {31'd0, o_irq}, 32'h1);
    rd(32'h4000_0004, rv, hv);
    check("coll_tl_reload", rv, 32'hFFFF_FFF0);
    idle(3);
    check("irq_sticky", {31'd0, o_irq}, 32'h1);

    // Disabled timer holds TL.
    wr(32'h4000_0008, 32'h0);
    wr(32'h4000_0004, 32'h7);
    idle(10);
    rd(32'h4000_0004, rv, hv);
    check("dis_tl", rv, 32'h7);
    check("dis_irq", {31'd0, o_irq}, 32'h0);

    // SYSTICK.
    rd(32'h4000_0014, ra, hv);
    idle(4);
    rd(32'h4000_0014, rb, hv);
    wr(32'h4000_0014, 32'h0);
    rd(32'h4000_0014, rv, hv);
`ifdef PERIPH_SYSTICK_EN
    check("systick_delta", rb - ra, 32'd4);
    check("systick_wr_ignored", rv, rb + 32'd1);
`else
    check("systick_absent", ra, 32'h0);
    check("systick_absent_wr", rv, 32'h0);
`endif

    // Reset in the middle of counting with a pending irq.
    wr(32'h4000_0008, 32'h7);
    check("pre_reset_irq", {31'd0, o_irq}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_irq", {31'd0, o_irq}, 32'h0);
    check("midreset_leds", {24'd0, o_leds}, 32'h0);
    rd(32'h4000_0004, rv, hv);
    check("midreset_tl", rv, 32'h0);
    rd(32'h4000_0008, rv, hv);
    check("midreset_tcon", rv, 32'h0);

    // Randomized traffic against the model, starting from a fresh reset.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    for (int it = 0; it < 400; it++) begin
      int          op;
      logic [2:0]  s;
      logic [31:0] a, d, exp_rd;
      logic        exp_hit;
      op = int'($urandom_range(0, 2));
      s  = 3'($urandom_range(0, 7));
      a  = BASE + {27'd0, s, 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h4000_0020 + {27'd0, s, 2'b00} : 32'h3FFF_FFE0 + {27'd0, s, 2'b00};
      d = $urandom;
      if (s == 3'd1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      exp_hit = (a[31:5] == BASE[31:5]);
      i_address = a; i_mem_write_data = d;
      i_mem_read = (op == 1); i_mem_write = (op == 2);
      #1;
      exp_rd = (op == 1 && exp_hit) ? m_read(a[4:2]) : 32'h0;
      check("rnd_rdata", o_mem_read_data, exp_rd);
      check("rnd_hit", {31'd0, o_hit}, {31'd0, exp_hit});
      check("rnd_irq", {31'd0, o_irq}, {31'd0, m_st & m_ie});
      check("rnd_leds", {24'd0, o_leds}, {24'd0, m_leds});
      check("rnd_digits", {20'd0, o_digits}, {20'd0, m_digits});
      m_step(op == 2 && exp_hit, a[4:2], d);
      @(negedge clk);
      i_mem_read = 1'b0; i_mem_write = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
